ipv4_vlg_tx: RTL and testbench

- IPv4 transmit path; the mirror of the IPv4 receiver.
- Accepts a per-packet request from an upper layer (UDP/TCP/ICMP) with destination, protocol and payload length.
- Builds and checksums the 20-byte header, then streams header followed by payload bytes to the MAC transmitter.
- Sits between the transport-layer arbiter and the MAC TX with ethertype IPv4 (0x0800). Options are never generated (IHL fixed at 5).

---
 rtl/ipv4_vlg_pkg.sv | 37 +++
 rtl/ipv4_vlg_cks.sv | 41 ++++
 rtl/ipv4_vlg_tx.sv | 217 +++++++++++++++++++++
 tb/tb_ipv4_vlg_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_vlg_pkg.sv
// Shared IPv4 definitions for the TX/RX paths: header layout, constants, FSM
// encoding and byte/word extraction helpers over the packed header.
package ipv4_vlg_pkg;

   localparam int          IPV4_HDR_LEN   = 20;
   localparam logic [15:0] IPV4_ETHERTYPE = 16'h0800;

   typedef struct packed {
      logic [3:0]  version;
      logic [3:0]  ihl;
      logic [7:0]  tos;
      logic [15:0] total_len;
      logic [15:0] id;
      logic [15:0] flags_frag;
      logic [7:0]  ttl;
      logic [7:0]  proto;
      logic [15:0] checksum;
      logic [31:0] src;
      logic [31:0] dst;
   } ipv4_hdr_t;

   typedef enum logic [2:0] {IDLE, CKS, FOLD, HDR, PLD, DONE} fsm_t;

   // Byte idx (0 = first on the wire) of the big-endian header.
   function automatic logic [7:0] hdr_byte(input ipv4_hdr_t h, input logic [4:0] idx);
      logic [159:0] v;
      v = h;
      return v[159 - 8*int'(idx) -: 8];
   endfunction

   function automatic logic [15:0] hdr_word(input ipv4_hdr_t h, input logic [3:0] idx);
      logic [159:0] v;
      v = h;
      return v[159 - 16*int'(idx) -: 16];
   endfunction

endpackage

// File: rtl/ipv4_vlg_cks.sv
// Sequential 16-bit one's-complement accumulator: clear, add one word per
// cycle into a 20-bit sum, then fold and store the complemented checksum.
module ipv4_vlg_cks
   import ipv4_vlg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        add,
   input  logic        fold,
   input  logic [15:0] word,
   output logic [15:0] cks
);

   logic [19:0] acc_r;
   logic [16:0] fold1_s;
   logic [15:0] fold2_s;

   // Two end-around carry adds; the second can never carry again.
   always_comb begin
      fold1_s = {1'b0, acc_r[15:0]} + {13'd0, acc_r[19:16]};
      fold2_s = fold1_s[15:0] + {15'd0, fold1_s[16]};
   end

   // Accumulator and folded checksum register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= 20'd0;
         cks   <= 16'd0;
      end else if (clr) begin
         acc_r <= 20'd0;
      end else if (add) begin
         acc_r <= acc_r + {4'd0, word};
      end else if (fold) begin
         cks <= ~fold2_s;
      end else begin
         acc_r <= acc_r;
      end
   end

endmodule

// File: rtl/ipv4_vlg_tx.sv
// IPv4 transmit path: accepts a packet request, checksums the 20-byte header,
// then streams header and pass-through payload to the MAC transmitter.
module ipv4_vlg_tx
   import ipv4_vlg_pkg::*;
#(
   parameter int TTL           = 64,
   parameter int MTU           = 1500,
   parameter int STALL_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dev_ipv4_addr,
   input  logic        req,
   input  logic [31:0] req_dst_ip,
   input  logic [47:0] req_dst_mac,
   input  logic [7:0]  req_proto,
   input  logic [15:0] req_pld_len,
   output logic        busy,
   input  logic [7:0]  pld_dat,
   input  logic        pld_val,
   output logic        pld_rdy,
   output logic [7:0]  mac_dat,
   output logic        mac_val,
   output logic        mac_sof,
   output logic        mac_eof,
   output logic        mac_err,
   input  logic        mac_rdy,
   output logic [47:0] mac_dst,
   output logic [15:0] mac_ethertype,
   output logic        done,
   output logic        rej
);

   fsm_t        state_r;
   logic [4:0]  cnt_r;
   logic [15:0] id_cnt_r;
   logic [15:0] id_r;
   logic [15:0] len_r;
   logic [31:0] src_ip_r;
   logic [31:0] dst_ip_r;
   logic [7:0]  proto_r;
   logic [15:0] pcnt_r;
   logic [15:0] stall_r;

   ipv4_hdr_t   hdr_s;
   logic [15:0] cks_s;
   logic [15:0] word_s;
   logic        oversize_s;
   logic        accept_s;
   logic        abort_s;
   logic        beat_s;

   assign mac_ethertype = IPV4_ETHERTYPE;
   assign oversize_s    = ({1'b0, req_pld_len} + 17'(IPV4_HDR_LEN)) > 17'(MTU);
   assign accept_s      = (state_r == IDLE) && req && !oversize_s;

   // Header image from latched request fields and the folded checksum.
   always_comb begin
      hdr_s.version    = 4'd4;
      hdr_s.ihl        = 4'd5;
      hdr_s.tos        = 8'h00;
      hdr_s.total_len  = len_r + 16'(IPV4_HDR_LEN);
      hdr_s.id         = id_r;
      hdr_s.flags_frag = 16'h4000;
      hdr_s.ttl        = 8'(TTL);
      hdr_s.proto      = proto_r;
      hdr_s.checksum   = cks_s;
      hdr_s.src        = src_ip_r;
      hdr_s.dst        = dst_ip_r;
      if (cnt_r == 5'd5) begin
         word_s = 16'h0000;
      end else begin
         word_s = hdr_word(hdr_s, cnt_r[3:0]);
      end
   end

   ipv4_vlg_cks u_cks (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept_s),
      .add  (state_r == CKS),
      .fold (state_r == FOLD),
      .word (word_s),
      .cks  (cks_s)
   );

   // MAC beat and payload handshake; payload is passed through with no latency.
   always_comb begin
      mac_dat = 8'h00;
      mac_val = 1'b0;
      mac_sof = 1'b0;
      mac_eof = 1'b0;
      mac_err = 1'b0;
      pld_rdy = 1'b0;
      abort_s = 1'b0;
      case (state_r)
         HDR: begin
            mac_val = 1'b1;
            mac_dat = hdr_byte(hdr_s, cnt_r);
            mac_sof = (cnt_r == 5'd0);
            mac_eof = (cnt_r == 5'd19) && (len_r == 16'd0);
         end
         PLD: begin
            if (stall_r == 16'(STALL_TIMEOUT)) begin
               abort_s = 1'b1;
               mac_val = 1'b1;
               mac_err = 1'b1;
               mac_eof = 1'b1;
            end else begin
               mac_val = pld_val;
               mac_dat = pld_dat;
               pld_rdy = pld_val && mac_rdy;
               mac_eof = pld_val && (pcnt_r == len_r - 16'd1);
            end
         end
         default: mac_val = 1'b0;
      endcase
      beat_s = mac_val && mac_rdy;
   end

   // Packet sequencing FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= 5'd0;
         id_cnt_r <= 16'd0;
         id_r     <= 16'd0;
         len_r    <= 16'd0;
         src_ip_r <= 32'd0;
         dst_ip_r <= 32'd0;
         proto_r  <= 8'd0;
         pcnt_r   <= 16'd0;
         stall_r  <= 16'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rej      <= 1'b0;
         mac_dst  <= 48'd0;
      end else begin
         done <= 1'b0;
         rej  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req && oversize_s) begin
                  rej <= 1'b1;
               end else if (accept_s) begin
                  id_r     <= id_cnt_r;
                  id_cnt_r <= id_cnt_r + 16'd1;
                  len_r    <= req_pld_len;
                  src_ip_r <= dev_ipv4_addr;
                  dst_ip_r <= req_dst_ip;
                  proto_r  <= req_proto;
                  mac_dst  <= req_dst_mac;
                  busy     <= 1'b1;
                  cnt_r    <= 5'd0;
                  state_r  <= CKS;
               end else begin
                  state_r <= IDLE;
               end
            end
            CKS: begin
               if (cnt_r == 5'd9) begin
                  cnt_r   <= 5'd0;
                  state_r <= FOLD;
               end else begin
                  cnt_r <= cnt_r + 5'd1;
               end
            end
            FOLD: begin
               cnt_r   <= 5'd0;
               state_r <= HDR;
            end
            HDR: begin
               if (beat_s) begin
                  if (cnt_r == 5'd19) begin
                     pcnt_r  <= 16'd0;
                     stall_r <= 16'd0;
                     if (len_r == 16'd0) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                     end else begin
                        state_r <= PLD;
                     end
                  end else begin
                     cnt_r <= cnt_r + 5'd1;
                  end
               end
            end
            PLD: begin
               if (abort_s) begin
                  if (mac_rdy) begin
                     rej     <= 1'b1;
                     busy    <= 1'b0;
                     state_r <= DONE;
                  end
               end else if (beat_s) begin
                  stall_r <= 16'd0;
                  if (mac_eof) begin
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state_r <= DONE;
                  end else begin
                     pcnt_r <= pcnt_r + 16'd1;
                  end
               end else if (!pld_val) begin
                  stall_r <= stall_r + 16'd1;
               end else begin
                  stall_r <= stall_r;
               end
            end
            DONE:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ipv4_vlg_tx.sv
// Self-checking bench for ipv4_vlg_tx: directed packet scenarios with random
// payload/handshakes, compared against a byte-level IPv4 header model.
module tb_ipv4_vlg_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dev_ipv4_addr;
   logic        req;
   logic [31:0] req_dst_ip;
   logic [47:0] req_dst_mac;
   logic [7:0]  req_proto;
   logic [15:0] req_pld_len;
   logic        busy;
   logic [7:0]  pld_dat;
   logic        pld_val;
   logic        pld_rdy;
   logic [7:0]  mac_dat;
   logic        mac_val, mac_sof, mac_eof, mac_err;
   logic        mac_rdy;
   logic [47:0] mac_dst;
   logic [15:0] mac_ethertype;
   logic        done, rej;

   always #5 clk = ~clk;

   ipv4_vlg_tx #(.TTL(64), .MTU(1500), .STALL_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .dev_ipv4_addr(dev_ipv4_addr), .req(req),
      .req_dst_ip(req_dst_ip), .req_dst_mac(req_dst_mac), .req_proto(req_proto),
      .req_pld_len(req_pld_len), .busy(busy), .pld_dat(pld_dat), .pld_val(pld_val),
      .pld_rdy(pld_rdy), .mac_dat(mac_dat), .mac_val(mac_val), .mac_sof(mac_sof),
      .mac_eof(mac_eof), .mac_err(mac_err), .mac_rdy(mac_rdy), .mac_dst(mac_dst),
      .mac_ethertype(mac_ethertype), .done(done), .rej(rej)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rdy_mode = 0;
   int          gap_mode = 0;
   bit          hold_low = 1'b0;
   int          last_nrdy;
   logic [7:0]  pld_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  last_obs[$];
   logic [7:0]  mh [0:19];
   logic [159:0] kv = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference header: fields laid out byte by byte, checksum by plain end-around sum.
   task automatic model_hdr(input logic [15:0] len, input logic [15:0] id,
                            input logic [7:0] proto, input logic [31:0] dst);
      int s;
      logic [15:0] c;
      logic [15:0] tl;
      tl = len + 16'd20;
      mh[0] = 8'h45; mh[1] = 8'h00; mh[2] = tl[15:8]; mh[3] = tl[7:0];
      mh[4] = id[15:8]; mh[5] = id[7:0]; mh[6] = 8'h40; mh[7] = 8'h00;
      mh[8] = 8'd64; mh[9] = proto; mh[10] = 8'h00; mh[11] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         mh[12+i] = dev_ipv4_addr[31-8*i -: 8];
         mh[16+i] = dst[31-8*i -: 8];
      end
      s = 0;
      for (int i = 0; i < 10; i++) s += int'({mh[2*i], mh[2*i+1]});
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
      c = ~s[15:0];
      mh[10] = c[15:8];
      mh[11] = c[7:0];
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      case (rdy_mode)
         1:       mac_rdy = ~mac_rdy;
         2:       mac_rdy = ($urandom_range(0, 3) != 0);
         default: mac_rdy = 1'b1;
      endcase
      if (pld_q.size() > 0 && !hold_low && (gap_mode != 1 || $urandom_range(0, 3) != 0)) begin
         pld_val = 1'b1;
         pld_dat = pld_q[0];
      end else begin
         pld_val = 1'b0;
         pld_dat = 8'($urandom);
      end
      #2;
      if (pld_val && pld_rdy) void'(pld_q.pop_front());
   endtask

   // gmode: 0 no gaps, 1 random gaps, 2 payload stops after 3 bytes (abort expected)
   task automatic send_packet(input logic [31:0] dst, input logic [47:0] dmac,
                              input logic [7:0] proto, input logic [15:0] len,
                              input logic [15:0] id, input int rmode, input int gmode,
                              input string tag);
      int n_start, sof_cyc, eof_cyc, end_cyc, err_cyc, lastp_cyc, n_pld, bad_rdy, eof_idx, n_eof, n_sof;
      bit seen_done, seen_rej, busy_at_end;
      logic [47:0] dst_seen;
      logic [7:0]  b;
      model_hdr(len, id, proto, dst);
      exp_q.delete();
      pld_q.delete();
      last_obs.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back(mh[i]);
      for (int i = 0; i < int'(len); i++) begin
         b = 8'($urandom);
         pld_q.push_back(b);
         exp_q.push_back(b);
      end
      rdy_mode = rmode; gap_mode = gmode; hold_low = 1'b0;
      sof_cyc = -1; eof_cyc = -1; end_cyc = -1; err_cyc = -1; lastp_cyc = -1;
      n_pld = 0; bad_rdy = 0; eof_idx = -1; n_eof = 0; n_sof = 0; last_nrdy = 0;
      seen_done = 1'b0; seen_rej = 1'b0; busy_at_end = 1'b1; dst_seen = 48'd0;
      req_dst_ip = dst; req_dst_mac = dmac; req_proto = proto; req_pld_len = len;
      req = 1'b1;
      n_start = cyc;
      for (int k = 0; k < 5000 && !(seen_done || seen_rej); k++) begin
         step();
         if (busy) req = 1'b0;
         if (pld_rdy) last_nrdy++;
         if (pld_rdy && !(pld_val && mac_rdy)) bad_rdy++;
         if (mac_val && mac_sof && sof_cyc < 0) begin
            sof_cyc = cyc;
            dst_seen = mac_dst;
         end
         if (mac_val && mac_rdy) begin
            if (mac_sof) n_sof++;
            if (mac_eof) begin n_eof++; eof_idx = last_obs.size(); eof_cyc = cyc; end
            if (mac_err) err_cyc = cyc;
            if (pld_rdy) begin
               n_pld++;
               lastp_cyc = cyc;
               if (gmode == 2 && n_pld == 3) hold_low = 1'b1;
            end
            last_obs.push_back(mac_dat);
         end
         if (done) begin seen_done = 1'b1; end_cyc = cyc; busy_at_end = busy; end
         if (rej)  begin seen_rej  = 1'b1; end_cyc = cyc; busy_at_end = busy; end
      end
      req = 1'b0;
      check({tag, "_sof_latency"}, 64'(sof_cyc), 64'(n_start + 12));
      check({tag, "_sof_count"}, 64'(n_sof), 64'd1);
      check({tag, "_mac_dst"}, {16'd0, dst_seen}, {16'd0, dmac});
      check({tag, "_pld_rdy_qual"}, 64'(bad_rdy), 64'd0);
      check({tag, "_busy_at_end"}, {63'd0, busy_at_end}, 64'd0);
      if (gmode == 2) begin
         check({tag, "_rej"}, {63'd0, seen_rej}, 64'd1);
         check({tag, "_no_done"}, {63'd0, seen_done}, 64'd0);
         check({tag, "_beats"}, 64'(last_obs.size()), 64'd24);
         check({tag, "_eof_idx"}, 64'(eof_idx), 64'd23);
         check({tag, "_err_after_stall"}, 64'(err_cyc - lastp_cyc), 64'd17);
         check({tag, "_rej_latency"}, 64'(end_cyc), 64'(err_cyc + 1));
         for (int i = 0; i < 23 && i < last_obs.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {56'd0, last_obs[i]}, {56'd0, exp_q[i]});
      end else begin
         check({tag, "_done"}, {63'd0, seen_done}, 64'd1);
         check({tag, "_no_rej"}, {63'd0, seen_rej}, 64'd0);
         check({tag, "_beats"}, 64'(last_obs.size()), 64'(exp_q.size()));
         check({tag, "_eof_count"}, 64'(n_eof), 64'd1);
         check({tag, "_eof_idx"}, 64'(eof_idx), 64'(exp_q.size() - 1));
         check({tag, "_done_latency"}, 64'(end_cyc), 64'(eof_cyc + 1));
         check({tag, "_no_err"}, 64'(err_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
         for (int i = 0; i < exp_q.size() && i < last_obs.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {56'd0, last_obs[i]}, {56'd0, exp_q[i]});
      end
      rdy_mode = 0; gap_mode = 0; hold_low = 1'b0;
      pld_q.delete();
      step();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_mac_sigs"}, {59'd0, mac_val, mac_sof, mac_eof, mac_err, pld_rdy}, 64'd0);
      check({tag, "_mac_dat"}, {56'd0, mac_dat}, 64'd0);
      check({tag, "_done_rej"}, {62'd0, done, rej}, 64'd0);
      check({tag, "_mac_dst"}, {16'd0, mac_dst}, 64'd0);
      check({tag, "_ethertype"}, {48'd0, mac_ethertype}, 64'h0800);
   endtask

   initial begin
      int n, nbusy, nval, rej_cyc, n_start;
      rst = 1'b1; req = 1'b0; dev_ipv4_addr = 32'hC0A8_0001;
      req_dst_ip = 32'd0; req_dst_mac = 48'd0; req_proto = 8'd0; req_pld_len = 16'd0;
      pld_dat = 8'd0; pld_val = 1'b0; mac_rdy = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check_quiet("reset");
      rst = 1'b0;
      step();

      // Known header vector from the 192.168.0.x example.
      send_packet(32'hC0A8_00C7, 48'h0200_1122_3344, 8'h11, 16'd95, 16'h0000, 0, 0, "vec");
      for (int i = 0; i < 20 && i < last_obs.size(); i++)
         check($sformatf("vec_const%0d", i), {56'd0, last_obs[i]}, {56'd0, kv[159-8*i -: 8]});

      send_packet(32'h0A00_0002, 48'h0200_0000_0001, 8'h01, 16'd0, 16'h0001, 0, 0, "zero");
      check("zero_len_hi", {56'd0, last_obs[2]}, 64'h00);
      check("zero_len_lo", {56'd0, last_obs[3]}, 64'h14);
      check("zero_pld_rdy", 64'(last_nrdy), 64'd0);

      send_packet(32'h0A00_0003, 48'h0200_0000_0002, 8'h06, 16'd8, 16'h0002, 1, 0, "bp");

      for (int p = 0; p < 4; p++)
         send_packet($urandom, {16'h0200, 32'($urandom)}, 8'($urandom),
                     16'($urandom_range(1, 60)), 16'(3 + p), 2, 1, $sformatf("rnd%0d", p));

      // Oversize request: 1481 + 20 = 1501 bytes.
      req_pld_len = 16'd1481; req_dst_ip = 32'h0A00_0009; req = 1'b1;
      n_start = cyc; rej_cyc = -1; nbusy = 0; nval = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (rej && rej_cyc < 0) rej_cyc = cyc;
         req = 1'b0;
         if (busy) nbusy++;
         if (mac_val) nval++;
      end
      check("over_rej_latency", 64'(rej_cyc), 64'(n_start + 1));
      check("over_busy", 64'(nbusy), 64'd0);
      check("over_mac_val", 64'(nval), 64'd0);
      send_packet(32'h0A00_000A, 48'h0200_0000_000A, 8'h11, 16'd1480, 16'h0007, 0, 0, "mtu");

      send_packet(32'h0A00_000B, 48'h0200_0000_000B, 8'h11, 16'd10, 16'h0008, 0, 2, "abort");
      send_packet(32'h0A00_000C, 48'h0200_0000_000C, 8'h11, 16'd5, 16'h0009, 0, 0, "after_abort");

      force dut.id_cnt_r = 16'hFFFF;
      step();
      release dut.id_cnt_r;
      send_packet(32'h0A00_000D, 48'h0200_0000_000D, 8'h11, 16'd4, 16'hFFFF, 2, 0, "wrap_ffff");
      send_packet(32'h0A00_000E, 48'h0200_0000_000E, 8'h11, 16'd4, 16'h0000, 0, 0, "wrap_0000");

      // Reset while payload is streaming.
      for (int i = 0; i < 10; i++) pld_q.push_back(8'($urandom));
      req_pld_len = 16'd10; req_dst_mac = 48'h0200_0000_00FF; req = 1'b1; n = 0;
      for (int k = 0; k < 200 && n < 2; k++) begin
         step();
         if (busy) req = 1'b0;
         if (pld_rdy) n++;
      end
      req = 1'b0;
      check("rst_reached_pld", {63'd0, n >= 2}, 64'd1);
      rst = 1'b1;
      step();
      check_quiet("rst_mid");
      rst = 1'b0;
      pld_q.delete();
      step();
      send_packet(32'h0A00_0010, 48'h0200_0000_0010, 8'h11, 16'd6, 16'h0000, 0, 0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
